// File: rtl/fifo_serializer_pkg.sv
// Shared types and constants for the FIFO feeder serializer.
// Holds the FSM state enum, the default geometry, and a beat-width helper.
package fifo_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam int unsigned DEF_MSBD  = 1;
    localparam int unsigned DEF_BEATS = 4;
    localparam int unsigned DEF_MSBC  = 1;
    localparam int unsigned DEF_MSBW  = 7;

    // Beat width and wide-word width for the default geometry
    localparam int unsigned BEAT_W = DEF_MSBD + 1;
    localparam int unsigned WORDW  = DEF_BEATS * BEAT_W;

    function automatic int unsigned beat_width(input int unsigned msbd);
        return msbd + 1;
    endfunction

endpackage

// File: rtl/fifo_serializer_if.sv
// Producer-side valid/ready bus plus FIFO push/full pins for fifo_serializer.
// Signals:
//   in_data/in_valid/in_ready : wide word handshake from the producer
//   push/dataIn               : beat strobe and data towards the FIFO
//   full                      : FIFO full flag
// Modports: slave = serializer side, master = producer/FIFO side.
interface fifo_serializer_if #(
    parameter int unsigned MSBD  = fifo_pkg::DEF_MSBD,
    parameter int unsigned BEATS = fifo_pkg::DEF_BEATS
);
    logic [BEATS*(MSBD+1)-1:0] in_data;
    logic                      in_valid;
    logic                      in_ready;
    logic                      push;
    logic [MSBD:0]             dataIn;
    logic                      full;

    modport slave (
        input  in_data, in_valid, full,
        output in_ready, push, dataIn
    );

    modport master (
        output in_data, in_valid, full,
        input  in_ready, push, dataIn
    );
endinterface

// File: rtl/fifo_serializer.sv
// Splits wide producer words into BEATS narrow beats (LSB beat first) and
// pushes them into a ring-buffer FIFO, stalling on the FIFO full flag.
// Ports:
//   clock      : system clock, rising edge
//   rst        : synchronous active-low reset
//   bus        : producer handshake + FIFO push/dataIn/full (slave modport)
//   busy       : a word is being serialised
//   words_sent : count of fully pushed words, wraps
module fifo_serializer
    import fifo_pkg::*;
#(
    parameter int unsigned MSBD  = DEF_MSBD,
    parameter int unsigned BEATS = DEF_BEATS,
    parameter int unsigned MSBC  = DEF_MSBC,
    parameter int unsigned MSBW  = DEF_MSBW
) (
    input  logic                 clock,
    input  logic                 rst,
    fifo_serializer_if.slave     bus,
    output logic                 busy,
    output logic [MSBW:0]        words_sent
);

    localparam int unsigned BEAT_BITS = beat_width(MSBD);
    localparam int unsigned WORD_BITS = BEATS * BEAT_BITS;
    localparam int unsigned CNT_W     = MSBC + 1;
    localparam int unsigned WCNT_W    = MSBW + 1;

    state_t                 r_state,  w_state_nxt;
    logic [WORD_BITS-1:0]   r_shreg,  w_shreg_nxt;
    logic [CNT_W-1:0]       r_cnt,    w_cnt_nxt;
    logic [WCNT_W-1:0]      r_words,  w_words_nxt;

    logic w_send;
    logic w_last;
    logic w_push;
    logic w_ready;
    logic w_accept;

    // Output decode; push and in_ready follow full combinationally
    assign w_send   = (r_state == SEND);
    assign w_last   = w_send && (r_cnt == CNT_W'(BEATS - 1));
    assign w_push   = w_send && !bus.full;
    assign w_ready  = !w_send || (w_last && !bus.full);
    assign w_accept = bus.in_valid && w_ready;

    assign bus.push     = w_push;
    assign bus.in_ready = w_ready;
    assign bus.dataIn   = w_send ? r_shreg[MSBD:0] : '0;
    assign busy         = w_send;
    assign words_sent   = r_words;

    // Next-state: a push consumes the current beat, an accept loads a new word.
    // Accept is evaluated last so a new word can replace the final beat in the
    // same cycle (zero-bubble back-to-back).
    always_comb begin
        w_state_nxt = r_state;
        w_shreg_nxt = r_shreg;
        w_cnt_nxt   = r_cnt;
        w_words_nxt = r_words;

        if (w_push) begin
            if (w_last) begin
                w_words_nxt = r_words + WCNT_W'(1);
                w_state_nxt = IDLE;
            end else begin
                w_shreg_nxt = r_shreg >> BEAT_BITS;
                w_cnt_nxt   = r_cnt + CNT_W'(1);
            end
        end

        if (w_accept) begin
            w_shreg_nxt = bus.in_data;
            w_cnt_nxt   = '0;
            w_state_nxt = SEND;
        end
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!rst) begin
            r_state <= IDLE;
            r_shreg <= '0;
            r_cnt   <= '0;
            r_words <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_shreg <= w_shreg_nxt;
            r_cnt   <= w_cnt_nxt;
            r_words <= w_words_nxt;
        end
    end

endmodule

// File: tb/tb_fifo_serializer.sv
// Self-checking bench for fifo_serializer: directed scenarios plus random
// producer/full/reset traffic, checked against a beat-queue reference model.
module tb_fifo_serializer;
    import fifo_pkg::*;

    localparam int unsigned MSBD  = 1;
    localparam int unsigned BEATS = 4;
    localparam int unsigned MSBC  = 1;
    localparam int unsigned BW    = MSBD + 1;
    localparam int unsigned WW    = BEATS * BW;

    logic          clock = 1'b0;
    logic          rst;
    logic [WW-1:0] drv_data;
    logic          drv_valid;
    logic          drv_full;

    always #5 clock = ~clock;

    fifo_serializer_if #(.MSBD(MSBD), .BEATS(BEATS)) bus_a ();
    fifo_serializer_if #(.MSBD(MSBD), .BEATS(BEATS)) bus_b ();

    assign bus_a.in_data  = drv_data;
    assign bus_a.in_valid = drv_valid;
    assign bus_a.full     = drv_full;
    assign bus_b.in_data  = drv_data;
    assign bus_b.in_valid = drv_valid;
    assign bus_b.full     = drv_full;

    logic       busy_a, busy_b;
    logic [7:0] ws_a;
    logic [1:0] ws_b;

    fifo_serializer #(.MSBD(MSBD), .BEATS(BEATS), .MSBC(MSBC), .MSBW(7)) dut (
        .clock(clock), .rst(rst), .bus(bus_a), .busy(busy_a), .words_sent(ws_a)
    );

    fifo_serializer #(.MSBD(MSBD), .BEATS(BEATS), .MSBC(MSBC), .MSBW(1)) dut_w (
        .clock(clock), .rst(rst), .bus(bus_b), .busy(busy_b), .words_sent(ws_b)
    );

    // Reference model: queue of beats still owed to the FIFO, plus word count
    logic [MSBD:0] exp_q[$];
    int unsigned   exp_words;
    bit            accepted;
    logic [MSBD:0] push_log[$];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: check outputs at negedge, then advance the model at posedge
    task automatic step();
        bit            m_push;
        bit            m_ready;
        logic [MSBD:0] m_data;
        @(negedge clock);
        m_push  = (exp_q.size() != 0) && !drv_full;
        m_ready = (exp_q.size() == 0) || (exp_q.size() == 1 && !drv_full);
        m_data  = (exp_q.size() != 0) ? exp_q[0] : '0;
        check_eq("push",     32'(bus_a.push),     32'(m_push));
        check_eq("in_ready", 32'(bus_a.in_ready), 32'(m_ready));
        check_eq("busy",     32'(busy_a),         32'(exp_q.size() != 0));
        check_eq("dataIn",   32'(bus_a.dataIn),   32'(m_data));
        check_eq("words",    32'(ws_a),           32'(exp_words % 256));
        check_eq("words_w",  32'(ws_b),           32'(exp_words % 4));
        check_eq("push_w",   32'(bus_b.push),     32'(m_push));
        if (bus_a.push) push_log.push_back(bus_a.dataIn);
        accepted = drv_valid && m_ready && rst;
        @(posedge clock);
        if (!rst) begin
            exp_q.delete();
            exp_words = 0;
        end else begin
            if (m_push) begin
                void'(exp_q.pop_front());
                if (exp_q.size() == 0) exp_words++;
            end
            if (accepted)
                for (int i = 0; i < int'(BEATS); i++)
                    exp_q.push_back(drv_data[i*BW +: BW]);
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        drv_valid = 1'b0;
        drv_full  = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    // Present a word and hold it until the model says it was taken
    task automatic send_word(input logic [WW-1:0] w);
        int n = 0;
        drv_valid = 1'b1;
        drv_data  = w;
        do begin
            step();
            n++;
        end while (!accepted && n < 64);
        check_eq("accept", 32'(accepted), 32'd1);
        drv_valid = 1'b0;
    endtask

    task automatic check_log(input string tag, input int unsigned exp[8], input int n);
        check_eq({tag, "_len"}, 32'(push_log.size()), 32'(n));
        for (int i = 0; i < n && i < push_log.size(); i++)
            check_eq(tag, 32'(push_log[i]), 32'(exp[i]));
    endtask

    int unsigned wrap_exp[5] = '{1, 2, 3, 0, 1};

    initial begin
        rst = 1'b0;
        drv_valid = 1'b0;
        drv_full  = 1'b0;
        drv_data  = '0;
        exp_words = 0;
        @(posedge clock);
        #1;

        // Reset and idle
        do_reset();
        step();
        check_eq("rst_push",  32'(bus_a.push),     32'd0);
        check_eq("rst_busy",  32'(busy_a),         32'd0);
        check_eq("rst_ready", 32'(bus_a.in_ready), 32'd1);
        check_eq("rst_words", 32'(ws_a),           32'd0);

        // Single word, no stall
        push_log.delete();
        send_word(8'hE4);
        repeat (BEATS + 1) step();
        check_log("single", '{0, 1, 2, 3, 0, 0, 0, 0}, 4);
        check_eq("single_words", 32'(ws_a), 32'd1);
        check_eq("single_busy",  32'(busy_a), 32'd0);

        // Full stall on cycles 2-3 after accept
        do_reset();
        push_log.delete();
        send_word(8'hE4);
        step();
        drv_full = 1'b1;
        step();
        check_eq("stall_data", 32'(bus_a.dataIn), 32'd1);
        check_eq("stall_push", 32'(bus_a.push),   32'd0);
        step();
        drv_full = 1'b0;
        repeat (BEATS + 1) step();
        check_log("stall", '{0, 1, 2, 3, 0, 0, 0, 0}, 4);

        // Back-to-back words
        do_reset();
        push_log.delete();
        send_word(8'hE4);
        send_word(8'h1B);
        repeat (BEATS + 1) step();
        check_log("b2b", '{0, 1, 2, 3, 3, 2, 1, 0}, 8);
        check_eq("b2b_words", 32'(ws_a), 32'd2);

        // Reset during the second beat of a word
        push_log.delete();
        send_word(8'hE4);
        step();
        rst = 1'b0;
        step();
        check_eq("mrst_push", 32'(bus_a.push), 32'd0);
        check_eq("mrst_busy", 32'(busy_a),     32'd0);
        rst = 1'b1;
        repeat (6) step();
        check_log("mrst", '{0, 1, 0, 0, 0, 0, 0, 0}, 2);
        check_eq("mrst_words", 32'(ws_a), 32'd0);

        // Narrow counter wrap
        for (int k = 0; k < 5; k++) begin
            send_word(WW'($urandom));
            repeat (BEATS) step();
            check_eq("wrap", 32'(ws_b), 32'(wrap_exp[k]));
        end

        // Random traffic: producer holds each word until accepted
        for (int c = 0; c < 3000; c++) begin
            drv_full = ($urandom_range(0, 99) < 30);
            rst      = ($urandom_range(0, 299) != 0);
            if (!drv_valid && $urandom_range(0, 1) == 1) begin
                drv_valid = 1'b1;
                drv_data  = WW'($urandom);
            end
            step();
            if (accepted) begin
                drv_valid = ($urandom_range(0, 1) == 1);
                drv_data  = WW'($urandom);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
